wb_reg_file: RTL and testbench

Writeback stage and architectural register file for the 5-stage ARM-subset pipeline. Sits downstream of the MEM/WB pipeline register and consumes its outputs: it selects the writeback value (memory data for loads, ALU result otherwise), commits it to one of 16 × 32-bit registers, and serves the two ID-stage read ports with same-cycle write-through bypass. It also exports the current writeback value and destination to the forwarding unit.

---
 rtl/wb_reg_file_if.sv | 36 +++
 rtl/wb_reg_file.sv | 45 ++++
 tb/tb_wb_reg_file.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_reg_file_if.sv
// wb_reg_file_if: MEM/WB-side bundle for the writeback stage and register file.
// slave: stage side (inputs from MEM/WB and ID, read/forward outputs); master: driver side.
interface wb_reg_file_if #(
  parameter int N_REGS = 16,
  parameter int W      = 32
);
  localparam int AW = $clog2(N_REGS);

  logic          WB_EN;
  logic          MEM_R;
  logic [W-1:0]  ALU_res;
  logic [W-1:0]  data_mem;
  logic [AW-1:0] dest;
  logic [AW-1:0] src1;
  logic [AW-1:0] src2;
  logic [W-1:0]  reg1;
  logic [W-1:0]  reg2;
  logic [W-1:0]  wb_value;
  logic [AW-1:0] wb_dest;
  logic          wb_en_out;
  logic [15:0]   wr_count;

  modport slave (
    input  WB_EN, MEM_R, ALU_res, data_mem,
    input  dest, src1, src2,
    output reg1, reg2, wb_value,
    output wb_dest, wb_en_out, wr_count
  );

  modport master (
    output WB_EN, MEM_R, ALU_res, data_mem,
    output dest, src1, src2,
    input  reg1, reg2, wb_value,
    input  wb_dest, wb_en_out, wr_count
  );
endinterface

// File: rtl/wb_reg_file.sv
// wb_reg_file: writeback select, register file commit, two bypassed read ports.
// Ports: clk, rst (async active-low), bus (wb_reg_file_if.slave).
module wb_reg_file #(
  parameter int N_REGS = 16,
  parameter int W      = 32
) (
  input  logic         clk,
  input  logic         rst,
  wb_reg_file_if.slave bus
);

  logic [W-1:0] regs_q [N_REGS];
  logic [15:0]  cnt_q;
  logic [15:0]  cnt_d;
  logic [W-1:0] wb_val;
  logic         byp1;
  logic         byp2;

  assign wb_val = bus.MEM_R ? bus.data_mem : bus.ALU_res;
  assign cnt_d  = cnt_q + 16'd1;

  // Write-through: a read of the register being committed this cycle
  // sees the incoming value, so ID never needs to stall on WB.
  assign byp1 = bus.WB_EN && (bus.src1 == bus.dest);
  assign byp2 = bus.WB_EN && (bus.src2 == bus.dest);

  assign bus.reg1      = byp1 ? wb_val : regs_q[bus.src1];
  assign bus.reg2      = byp2 ? wb_val : regs_q[bus.src2];
  assign bus.wb_value  = wb_val;
  assign bus.wb_dest   = bus.dest;
  assign bus.wb_en_out = bus.WB_EN;
  assign bus.wr_count  = cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REGS; i++)
        regs_q[i] <= '0;
      cnt_q <= '0;
    end else if (bus.WB_EN) begin
      regs_q[bus.dest] <= wb_val;
      cnt_q            <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_reg_file.sv
// tb_wb_reg_file: scoreboard bench for wb_reg_file.
// Expected values are queued when stimulus is driven and popped on compare.
module tb_wb_reg_file;
  localparam int NR = 16;
  localparam int W  = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_reg_file_if #(.N_REGS(NR), .W(W)) bus ();

  wb_reg_file #(.N_REGS(NR), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mdl [NR];
  logic [15:0] mdl_cnt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = 'x;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    chk(tag, obs, e);
  endtask

  task automatic drv(input logic we, input logic mr,
                     input logic [31:0] alu, input logic [31:0] dm,
                     input logic [AW-1:0] d, input logic [AW-1:0] s1,
                     input logic [AW-1:0] s2);
    bus.WB_EN    = we;
    bus.MEM_R    = mr;
    bus.ALU_res  = alu;
    bus.data_mem = dm;
    bus.dest     = d;
    bus.src1     = s1;
    bus.src2     = s2;
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    bus.WB_EN = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] e1, e2, ev;
    rst = 1'b0;
    drv(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 4'd3, 4'd3, 4'd0);

    // reset: bypass still live, regs path and counter stay zero
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    push(32'hDEAD_BEEF); pop_chk("rst_byp_reg1", bus.reg1);
    push(32'h0); pop_chk("rst_cnt", {16'h0, bus.wr_count});
    push(32'hDEAD_BEEF); pop_chk("rst_wbval", bus.wb_value);
    bus.WB_EN = 1'b0;
    #1;
    push(32'h0); pop_chk("rst_nobyp_reg1", bus.reg1);
    push(32'h0); pop_chk("rst_wben_out", {31'h0, bus.wb_en_out});
    @(posedge clk);
    #1;
    push(32'h0); pop_chk("rst_cnt2", {16'h0, bus.wr_count});
    @(negedge clk);
    rst = 1'b1;

    // ALU writeback
    @(negedge clk);
    drv(1'b1, 1'b0, 32'h1234_5678, 32'h0, 4'd5, 4'd0, 4'd0);
    @(posedge clk);
    #1;
    bus.WB_EN = 1'b0;
    bus.src1  = 4'd5;
    #1;
    push(32'h1234_5678); pop_chk("alu_reg1", bus.reg1);
    push(32'd1); pop_chk("alu_cnt", {16'h0, bus.wr_count});

    // load writeback
    @(negedge clk);
    drv(1'b1, 1'b1, 32'h40, 32'hCAFE_0001, 4'd7, 4'd0, 4'd0);
    #1;
    push(32'hCAFE_0001); pop_chk("ld_wbval", bus.wb_value);
    push(32'd7); pop_chk("ld_wbdest", 32'(bus.wb_dest));
    push(32'd1); pop_chk("ld_wben_out", {31'h0, bus.wb_en_out});
    @(posedge clk);
    #1;
    bus.WB_EN = 1'b0;
    bus.src2  = 4'd7;
    #1;
    push(32'hCAFE_0001); pop_chk("ld_reg2", bus.reg2);
    push(32'd2); pop_chk("ld_cnt", {16'h0, bus.wr_count});

    // bypass with disable
    @(negedge clk);
    drv(1'b1, 1'b0, 32'hAAAA_AAAA, 32'h0, 4'd2, 4'd0, 4'd0);
    @(negedge clk);
    drv(1'b1, 1'b0, 32'h5555_5555, 32'h0, 4'd2, 4'd2, 4'd2);
    #1;
    push(32'h5555_5555); pop_chk("byp_reg1", bus.reg1);
    push(32'h5555_5555); pop_chk("byp_reg2", bus.reg2);
    bus.WB_EN = 1'b0;
    #1;
    push(32'hAAAA_AAAA); pop_chk("nobyp_reg1", bus.reg1);
    push(32'hAAAA_AAAA); pop_chk("nobyp_reg2", bus.reg2);
    @(posedge clk);
    #1;
    push(32'hAAAA_AAAA); pop_chk("nobyp_kept", bus.reg1);
    push(32'd3); pop_chk("nobyp_cnt", {16'h0, bus.wr_count});

    // back-to-back writes to r15
    @(negedge clk);
    drv(1'b1, 1'b0, 32'h1, 32'h0, 4'd15, 4'd15, 4'd0);
    #1;
    push(32'h1); pop_chk("b2b_0", bus.reg1);
    @(posedge clk);
    #1;
    bus.ALU_res = 32'h2;
    #1;
    push(32'h2); pop_chk("b2b_1", bus.reg1);
    @(posedge clk);
    #1;
    bus.WB_EN = 1'b0;
    #1;
    push(32'h2); pop_chk("b2b_2", bus.reg1);
    push(32'd5); pop_chk("b2b_cnt", {16'h0, bus.wr_count});

    // random traffic against a reference model
    rst_pulse();
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    mdl_cnt = '0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      drv(1'($urandom), 1'($urandom), $urandom, $urandom,
          AW'($urandom), AW'($urandom), AW'($urandom));
      #1;
      ev = bus.MEM_R ? bus.data_mem : bus.ALU_res;
      e1 = (bus.WB_EN && bus.src1 == bus.dest) ? ev : mdl[bus.src1];
      e2 = (bus.WB_EN && bus.src2 == bus.dest) ? ev : mdl[bus.src2];
      push(ev); push(e1); push(e2); push({16'h0, mdl_cnt});
      pop_chk("rnd_wbval", bus.wb_value);
      pop_chk("rnd_reg1", bus.reg1);
      pop_chk("rnd_reg2", bus.reg2);
      pop_chk("rnd_cnt", {16'h0, bus.wr_count});
      @(posedge clk);
      if (bus.WB_EN) begin
        mdl[bus.dest] = ev;
        mdl_cnt++;
      end
    end

    // counter wrap after 65536 commits
    rst_pulse();
    @(negedge clk);
    drv(1'b1, 1'b0, 32'h0BAD_F00D, 32'h0, 4'd9, 4'd9, 4'd9);
    repeat (65535) @(posedge clk);
    #1;
    push(32'h0000_FFFF); pop_chk("wrap_ffff", {16'h0, bus.wr_count});
    @(posedge clk);
    #1;
    push(32'h0); pop_chk("wrap_zero", {16'h0, bus.wr_count});
    @(posedge clk);
    #1;
    bus.WB_EN = 1'b0;
    #1;
    push(32'd1); pop_chk("wrap_one", {16'h0, bus.wr_count});
    push(32'h0BAD_F00D); pop_chk("pre_arst_reg1", bus.reg1);

    // async reset mid-cycle, no clock edge in between
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    push(32'h0); pop_chk("arst_cnt", {16'h0, bus.wr_count});
    push(32'h0); pop_chk("arst_reg1", bus.reg1);
    push(32'h0); pop_chk("arst_reg2", bus.reg2);
    @(negedge clk);
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
